// File: rtl/pl_pkg.sv
// Shared types and constants for the program loader.
// Optional trailing checksum byte: define PROG_LOADER_CHECKSUM_EN.
package pl_pkg;

  localparam int W_DEF      = 16;
  localparam int ADDR_W_DEF = 10;

  // Header is big-endian: the count high byte arrives first.
  localparam int HDR_HI_IDX = 0;
  localparam int HDR_LO_IDX = 1;
  localparam int HDR_BYTES  = 2;

  typedef enum logic [2:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    DATA_HI,
    DATA_LO,
`ifdef PROG_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } pl_state_t;

endpackage

// File: rtl/pl_word_asm.sv
// Pairs program bytes into words and drives the imem write port.
// The write strobe is registered here and suppressed while rst is high.
module pl_word_asm
  import pl_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [7:0]        byte_in,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [W-1:0]      imem_wdata
);

  logic [7:0] hi_q;
  logic       we_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q       <= '0;
      we_q       <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      we_q <= lo_we;
      if (hi_we) hi_q <= byte_in;
      if (lo_we) begin
        imem_addr  <= addr_in;
        imem_wdata <= W'({hi_q, byte_in});
      end
    end
  end

  // A reset landing on the strobe cycle cancels the pending write.
  assign imem_we = we_q & ~rst;

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader that fills imem and holds the CPU in reset.
// Optional trailing checksum byte: define PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import pl_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [W-1:0]      imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  pl_state_t         state, state_n;
  logic [15:0]       count;
  logic [15:0]       cnt_full;
  logic [ADDR_W-1:0] idx;
  logic              xfer;
  logic              last;
  logic              start;
  logic              hi_we;
  logic              lo_we;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign xfer     = byte_valid & byte_ready;
  assign cnt_full = {count[15:8], byte_in};
  assign last     = 17'(idx) == (17'(count) - 17'd1);
  assign hi_we    = xfer & (state == DATA_HI);
  assign lo_we    = xfer & (state == DATA_LO);

  always_comb begin
    state_n    = state;
    byte_ready = 1'b0;
    start      = 1'b0;
    unique case (state)
      IDLE, DONE, ERR: begin
        if (load_start) begin
          state_n = CNT_HI;
          start   = 1'b1;
        end
      end
      CNT_HI: begin
        byte_ready = 1'b1;
        if (xfer) state_n = CNT_LO;
      end
      CNT_LO: begin
        byte_ready = 1'b1;
        if (xfer) begin
          if (cnt_full == 16'd0)
            state_n = DONE;
          else if (17'(cnt_full) > (17'd1 << ADDR_W))
            state_n = ERR;
          else
            state_n = DATA_HI;
        end
      end
      DATA_HI: begin
        byte_ready = 1'b1;
        if (xfer) state_n = DATA_LO;
      end
      DATA_LO: begin
        byte_ready = 1'b1;
        if (xfer) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_n = last ? CHK : DATA_HI;
`else
          state_n = last ? DONE : DATA_HI;
`endif
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHK: begin
        byte_ready = 1'b1;
        if (xfer) state_n = (byte_in == csum) ? DONE : ERR;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      idx   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum  <= '0;
`endif
    end else begin
      state <= state_n;
      if (start) begin
        count <= '0;
        idx   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum  <= '0;
`endif
      end
      if (xfer && state == CNT_HI) count[15:8] <= byte_in;
      if (xfer && state == CNT_LO) count[7:0]  <= byte_in;
      if (lo_we && !last) idx <= idx + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      if (xfer && state != CHK) csum <= csum ^ byte_in;
`endif
    end
  end

  assign cpu_rst = (state != DONE);
  assign done    = (state == DONE);
  assign error   = (state == ERR);

  pl_word_asm #(
    .W      (W),
    .ADDR_W (ADDR_W)
  ) u_asm (
    .clk        (clk),
    .rst        (rst),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .byte_in    (byte_in),
    .addr_in    (idx),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata)
  );

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (ADDR_W=10 and ADDR_W=2).
// Checksum cases run when PROG_LOADER_CHECKSUM_EN is defined.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst1, rst2;
  logic        load_start;
  logic [7:0]  byte_in;
  logic        byte_valid;

  logic        byte_ready, imem_we, cpu_rst, done, error;
  logic [9:0]  imem_addr;
  logic [15:0] imem_wdata;

  logic        byte_ready2, imem_we2, cpu_rst2, done2, error2;
  logic [1:0]  imem_addr2;
  logic [15:0] imem_wdata2;

  int checks = 0;
  int errors = 0;
  bit sel = 1'b0;

  logic [15:0] wa[$];
  logic [15:0] wd[$];
  logic [15:0] wa2[$];
  logic [15:0] wd2[$];

  always #5 clk = ~clk;

  prog_loader #(.W(16), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst1), .load_start(load_start),
    .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .done(done), .error(error)
  );

  prog_loader #(.W(16), .ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst2), .load_start(load_start),
    .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready2), .imem_we(imem_we2),
    .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
    .cpu_rst(cpu_rst2), .done(done2), .error(error2)
  );

  always @(negedge clk) begin
    if (imem_we) begin
      wa.push_back(16'(imem_addr));
      wd.push_back(imem_wdata);
    end
    if (imem_we2) begin
      wa2.push_back(16'(imem_addr2));
      wd2.push_back(imem_wdata2);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wa.delete();
    wd.delete();
    wa2.delete();
    wd2.delete();
  endtask

  task automatic start_load();
    load_start = 1'b1;
    @(posedge clk);
    #1 load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clk);
    while (!(sel ? byte_ready2 : byte_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      errors++;
      $display("FAIL ready_timeout: got 0 want 1");
    end
    @(posedge clk);
    #1 byte_valid = 1'b0;
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_stream(input logic [7:0] q[$], input bit gap);
    logic [7:0] cs = 8'h00;
    foreach (q[i]) begin
      send_byte(q[i], gap);
      cs ^= q[i];
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(cs, gap);
`endif
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst1 = 1'b1; rst2 = 1'b1;
    load_start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst1 = 1'b0;
    settle();
    check("rst_ready", byte_ready, 0);
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);

    // Two words, valid held high
    @(posedge clk); #1;
    clear_logs();
    start_load();
    check("start_ready", byte_ready, 1);
    check("start_cpu_rst", cpu_rst, 1);
    send_stream('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD}, 1'b0);
    settle();
    check("s1_done", done, 1);
    check("s1_cpu_rst", cpu_rst, 0);
    check("s1_error", error, 0);
    check("s1_nwr", wa.size(), 2);
    if (wa.size() == 2) begin
      check("s1_a0", wa[0], 16'h0000);
      check("s1_d0", wd[0], 16'h1234);
      check("s1_a1", wa[1], 16'h0001);
      check("s1_d1", wd[1], 16'hABCD);
    end
    settle();
    check("hold_we", imem_we, 0);
    check("hold_addr", imem_addr, 10'd1);
    check("hold_wdata", imem_wdata, 16'hABCD);
    check("s1_ready_done", byte_ready, 0);

    // Same stream, gaps between bytes, stray load_start mid-load
    @(posedge clk); #1;
    clear_logs();
    start_load();
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    start_load();
    check("ignore_start", byte_ready, 1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h42, 1'b1);
`endif
    settle();
    check("s2_done", done, 1);
    check("s2_nwr", wa.size(), 2);
    if (wa.size() == 2) begin
      check("s2_a0", wa[0], 16'h0000);
      check("s2_d0", wd[0], 16'h1234);
      check("s2_a1", wa[1], 16'h0001);
      check("s2_d1", wd[1], 16'hABCD);
    end

    // Zero count goes straight to DONE
    clear_logs();
    start_load();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    settle();
    check("n0_done", done, 1);
    check("n0_cpu_rst", cpu_rst, 0);
    check("n0_nwr", wa.size(), 0);

    // Count 0x0401 exceeds depth 1024
    clear_logs();
    start_load();
    send_byte(8'h04, 1'b0);
    send_byte(8'h01, 1'b0);
    settle();
    check("big_error", error, 1);
    check("big_done", done, 0);
    check("big_cpu_rst", cpu_rst, 1);
    check("big_ready", byte_ready, 0);
    check("big_nwr", wa.size(), 0);

    // Reset on the strobe cycle of word 0
    clear_logs();
    start_load();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    rst1 = 1'b1;
    settle();
    check("abort_we", imem_we, 0);
    @(posedge clk);
    #1 rst1 = 1'b0;
    settle();
    check("abort_nwr", wa.size(), 0);
    check("abort_ready", byte_ready, 0);
    check("abort_cpu_rst", cpu_rst, 1);
    check("abort_done", done, 0);
    check("abort_error", error, 0);
    check("abort_addr", imem_addr, 0);
    check("abort_wdata", imem_wdata, 0);

`ifdef PROG_LOADER_CHECKSUM_EN
    clear_logs();
    start_load();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h27, 1'b0);
    settle();
    check("cs_ok_done", done, 1);
    check("cs_ok_cpu_rst", cpu_rst, 0);
    check("cs_ok_nwr", wa.size(), 1);
    start_load();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h00, 1'b0);
    settle();
    check("cs_bad_error", error, 1);
    check("cs_bad_done", done, 0);
    check("cs_bad_cpu_rst", cpu_rst, 1);
`endif

    // Full depth on the ADDR_W=2 instance
    @(posedge clk);
    #1 rst2 = 1'b0;
    clear_logs();
    sel = 1'b1;
    start_load();
    send_stream('{8'h00, 8'h04, 8'h11, 8'h11, 8'h22, 8'h22,
                  8'h33, 8'h33, 8'h44, 8'h44}, 1'b0);
    settle();
    check("full_done", done2, 1);
    check("full_nwr", wa2.size(), 4);
    if (wa2.size() == 4) begin
      check("full_a3", wa2[3], 16'h0003);
      check("full_d3", wd2[3], 16'h4444);
      check("full_a0", wa2[0], 16'h0000);
      check("full_d2", wd2[2], 16'h3333);
    end
    check("full_ready", byte_ready2, 0);
    byte_in = 8'h55;
    byte_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1 byte_valid = 1'b0;
    settle();
    check("full_nowrap", wa2.size(), 4);
    check("full_done_hold", done2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
